// File: rtl/program_counter_stack.sv
`default_nettype none
// ============================================================================
// Module      : program_counter_stack
// Description : Parametrised program counter with absolute / programming-mode
//               load, signed relative branch and a call/return address stack
//               with sticky overflow/underflow error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module program_counter_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int OFS_W = 4
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         EN,
    input  logic                         WE,
    input  logic                         PRGM,
    input  logic [WIDTH-1:0]             PC_IN,
    input  logic                         BR,
    input  logic [OFS_W-1:0]             OFFSET,
    input  logic                         CALL,
    input  logic                         RET,
    output logic [WIDTH-1:0]             COUNT,
    output logic                         ON,
    output logic [$clog2(DEPTH+1)-1:0]   SP,
    output logic                         STK_FULL,
    output logic                         STK_EMPTY,
    output logic                         ERR,
    output logic                         WRAP
);

    // SP must represent 0..DEPTH; stack index only needs 0..DEPTH-1.
    localparam int c_SP_W  = $clog2(DEPTH + 1);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_ENTRIES = 2 ** c_IDX_W;

    logic [WIDTH-1:0]  r_count;
    logic [c_SP_W-1:0] r_sp;
    logic              r_err;
    logic              r_wrap;
    logic [WIDTH-1:0]  r_stack [c_ENTRIES];

    logic [WIDTH-1:0]  w_count_inc;
    logic [WIDTH-1:0]  w_ofs_ext;
    logic [c_SP_W-1:0] w_sp_dec;
    logic              w_full;
    logic              w_empty;
    logic              w_push;

    assign w_count_inc = r_count + WIDTH'(1);
    // Size cast of a signed operand sign-extends, also valid when OFS_W == WIDTH.
    assign w_ofs_ext   = WIDTH'($signed(OFFSET));
    assign w_sp_dec    = r_sp - c_SP_W'(1);
    assign w_full      = (r_sp == c_SP_W'(DEPTH));
    assign w_empty     = (r_sp == '0);

    // A push happens only when CALL wins arbitration and the stack has room.
    assign w_push = !PRGM && !WE && EN && !RET && CALL && !w_full;

    // Prioritised single-action update of counter, stack pointer and flags.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            r_count <= '0;
            r_sp    <= '0;
            r_err   <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (PRGM) begin
                r_count <= PC_IN;
            end else if (WE) begin
                r_count <= PC_IN;
            end else if (EN && RET) begin
                if (!w_empty) begin
                    r_count <= r_stack[w_sp_dec[c_IDX_W-1:0]];
                    r_sp    <= w_sp_dec;
                end else begin
                    r_err <= 1'b1;
                end
            end else if (EN && CALL) begin
                if (!w_full) begin
                    r_count <= PC_IN;
                    r_sp    <= r_sp + c_SP_W'(1);
                end else begin
                    r_err <= 1'b1;
                end
            end else if (EN && BR) begin
                r_count <= r_count + w_ofs_ext;
            end else if (EN) begin
                r_count <= w_count_inc;
                r_wrap  <= &r_count;
            end
        end
    end

    // Return-address storage; contents are don't-care after reset.
    always_ff @(posedge CLK) begin
        if (RESET_N && w_push) begin
            r_stack[r_sp[c_IDX_W-1:0]] <= w_count_inc;
        end
    end

    assign COUNT     = r_count;
    assign ON        = EN;
    assign SP        = r_sp;
    assign STK_FULL  = w_full;
    assign STK_EMPTY = w_empty;
    assign ERR       = r_err;
    assign WRAP      = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_program_counter_stack.sv
`default_nettype none
// ============================================================================
// Module      : tb_program_counter_stack
// Description : Directed testbench for program_counter_stack with a
//               behavioural reference model feeding an expectation queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_program_counter_stack;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int OFS_W = 4;
    localparam int SP_W  = $clog2(DEPTH + 1);

    logic             CLK;
    logic             RESET_N;
    logic             EN;
    logic             WE;
    logic             PRGM;
    logic [WIDTH-1:0] PC_IN;
    logic             BR;
    logic [OFS_W-1:0] OFFSET;
    logic             CALL;
    logic             RET;
    logic [WIDTH-1:0] COUNT;
    logic             ON;
    logic [SP_W-1:0]  SP;
    logic             STK_FULL;
    logic             STK_EMPTY;
    logic             ERR;
    logic             WRAP;

    program_counter_stack #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .OFS_W (OFS_W)
    ) dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .EN        (EN),
        .WE        (WE),
        .PRGM      (PRGM),
        .PC_IN     (PC_IN),
        .BR        (BR),
        .OFFSET    (OFFSET),
        .CALL      (CALL),
        .RET       (RET),
        .COUNT     (COUNT),
        .ON        (ON),
        .SP        (SP),
        .STK_FULL  (STK_FULL),
        .STK_EMPTY (STK_EMPTY),
        .ERR       (ERR),
        .WRAP      (WRAP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic [SP_W-1:0]  sp;
        logic             err;
        logic             wrap;
    } exp_t;

    exp_t q_exp[$];

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [WIDTH-1:0] m_count;
    int               m_sp;
    logic             m_err;
    logic             m_wrap;
    logic [WIDTH-1:0] m_stack [DEPTH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model(input logic rst_n, input logic en, input logic we, input logic prgm,
                         input logic br, input logic call, input logic ret,
                         input logic [WIDTH-1:0] pc, input logic [OFS_W-1:0] ofs);
        logic [WIDTH-1:0] sext;
        sext = {{(WIDTH-OFS_W){ofs[OFS_W-1]}}, ofs};
        if (!rst_n) begin
            m_count = '0; m_sp = 0; m_err = 1'b0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (prgm || we) begin
                m_count = pc;
            end else if (en && ret) begin
                if (m_sp > 0) begin
                    m_sp    = m_sp - 1;
                    m_count = m_stack[m_sp];
                end else begin
                    m_err = 1'b1;
                end
            end else if (en && call) begin
                if (m_sp < DEPTH) begin
                    m_stack[m_sp] = m_count + 8'd1;
                    m_sp    = m_sp + 1;
                    m_count = pc;
                end else begin
                    m_err = 1'b1;
                end
            end else if (en && br) begin
                m_count = m_count + sext;
            end else if (en) begin
                m_wrap  = (m_count == 8'hFF);
                m_count = m_count + 8'd1;
            end
        end
    endtask

    // One clock: drive inputs, queue the model's prediction, compare after the edge.
    task automatic step(input logic rst_n, input logic en, input logic we, input logic prgm,
                        input logic br, input logic call, input logic ret,
                        input logic [WIDTH-1:0] pc, input logic [OFS_W-1:0] ofs);
        exp_t e;
        RESET_N = rst_n; EN = en; WE = we; PRGM = prgm;
        BR = br; CALL = call; RET = ret; PC_IN = pc; OFFSET = ofs;
        #1;
        chk("ON", {31'd0, ON}, {31'd0, en});
        model(rst_n, en, we, prgm, br, call, ret, pc, ofs);
        e.count = m_count; e.sp = SP_W'(m_sp); e.err = m_err; e.wrap = m_wrap;
        q_exp.push_back(e);
        @(posedge CLK);
        #1;
        e = q_exp.pop_front();
        chk("COUNT", {24'd0, COUNT}, {24'd0, e.count});
        chk("SP", {29'd0, SP}, {29'd0, e.sp});
        chk("ERR", {31'd0, ERR}, {31'd0, e.err});
        chk("WRAP", {31'd0, WRAP}, {31'd0, e.wrap});
        chk("STK_FULL", {31'd0, STK_FULL}, {31'd0, (e.sp == SP_W'(DEPTH))});
        chk("STK_EMPTY", {31'd0, STK_EMPTY}, {31'd0, (e.sp == '0)});
    endtask

    // Shorthands
    task automatic do_reset();                    step(0,0,0,0,0,0,0,8'h00,4'h0); endtask
    task automatic do_load(input logic [7:0] a);  step(1,0,1,0,0,0,0,a,4'h0);     endtask
    task automatic do_call(input logic [7:0] a);  step(1,1,0,0,0,1,0,a,4'h0);     endtask
    task automatic do_ret();                      step(1,1,0,0,0,0,1,8'h00,4'h0); endtask
    task automatic do_br(input logic [3:0] o);    step(1,1,0,0,1,0,0,8'h00,o);    endtask

    initial begin
        int wraps;
        RESET_N = 1'b0; EN = 1'b0; WE = 1'b0; PRGM = 1'b0; PC_IN = '0;
        BR = 1'b0; OFFSET = '0; CALL = 1'b0; RET = 1'b0;
        m_count = '0; m_sp = 0; m_err = 1'b0; m_wrap = 1'b0;

        // Reset state
        do_reset();
        chk("rst_count", {24'd0, COUNT}, 32'h0);
        chk("rst_empty", {31'd0, STK_EMPTY}, 32'h1);

        // Count through full range with wrap pulse
        wraps = 0;
        for (int i = 0; i < 257; i++) begin
            step(1,1,0,0,0,0,0,8'h00,4'h0);
            if (WRAP) wraps++;
            if (COUNT == 8'h00) chk("wrap_at_zero", {31'd0, WRAP}, 32'h1);
        end
        chk("count_after_257", {24'd0, COUNT}, 32'h01);
        chk("wrap_count", wraps, 32'd1);

        // Priority: PRGM+WE+CALL -> load only; then CALL+RET with empty stack -> underflow
        do_load(8'h10);
        step(1,1,1,1,0,1,0,8'h40,4'h0);
        chk("prio_count", {24'd0, COUNT}, 32'h40);
        chk("prio_sp", {29'd0, SP}, 32'h0);
        step(1,1,0,0,0,1,1,8'h77,4'h0);
        chk("underflow_count", {24'd0, COUNT}, 32'h40);
        chk("underflow_err", {31'd0, ERR}, 32'h1);
        do_load(8'h33);
        chk("err_sticky_load", {31'd0, ERR}, 32'h1);

        // Nested call/return
        do_reset();
        do_load(8'h05);
        do_call(8'h20);
        do_call(8'h30);
        chk("nest_sp", {29'd0, SP}, 32'h2);
        do_ret();
        chk("nest_ret1", {24'd0, COUNT}, 32'h21);
        do_ret();
        chk("nest_ret2", {24'd0, COUNT}, 32'h06);
        chk("nest_empty", {31'd0, STK_EMPTY}, 32'h1);

        // Overflow and LIFO pops
        do_reset();
        do_load(8'h50);
        do_call(8'h60);
        do_call(8'h70);
        do_call(8'h80);
        do_call(8'h90);
        chk("ovf_full", {31'd0, STK_FULL}, 32'h1);
        do_call(8'h99);
        chk("ovf_count", {24'd0, COUNT}, 32'h90);
        chk("ovf_err", {31'd0, ERR}, 32'h1);
        chk("ovf_sp", {29'd0, SP}, 32'h4);
        do_ret(); chk("lifo1", {24'd0, COUNT}, 32'h81);
        do_ret(); chk("lifo2", {24'd0, COUNT}, 32'h71);
        do_ret(); chk("lifo3", {24'd0, COUNT}, 32'h61);
        do_ret(); chk("lifo4", {24'd0, COUNT}, 32'h51);

        // Relative branch, negative then positive
        do_reset();
        do_load(8'h02);
        do_br(4'b1100);
        chk("br_neg", {24'd0, COUNT}, 32'hFE);
        chk("br_nowrap", {31'd0, WRAP}, 32'h0);
        do_br(4'b0111);
        chk("br_pos", {24'd0, COUNT}, 32'h05);

        // Reset mid-operation, then idle with EN=0
        do_reset();
        do_ret();
        do_call(8'h11);
        do_call(8'h22);
        do_call(8'h33);
        chk("pre_rst_sp", {29'd0, SP}, 32'h3);
        step(0,1,0,0,0,1,0,8'hAA,4'h0);
        chk("midrst_count", {24'd0, COUNT}, 32'h0);
        chk("midrst_err", {31'd0, ERR}, 32'h0);
        for (int i = 0; i < 10; i++) begin
            step(1,0,0,0,(i%3)==0,(i%3)==1,(i%3)==2,8'hC3,4'h5);
        end
        chk("idle_count", {24'd0, COUNT}, 32'h0);
        chk("idle_sp", {29'd0, SP}, 32'h0);

        // WE + CALL: load only, SP untouched
        step(1,1,1,0,0,1,0,8'h5A,4'h0);
        chk("we_call_count", {24'd0, COUNT}, 32'h5A);
        chk("we_call_sp", {29'd0, SP}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
